// File: rtl/layer_ser_pkg.sv
// Shared types and default sizes for the neuron-layer output serializer
// and the neuron/layer wrappers that feed it.
package layer_ser_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, GAP} ser_state_t;

  localparam int NUM_NEURON_DEF = 30;
  localparam int DATA_W_DEF     = 16;

endpackage

// File: rtl/layer_collect_buf.sv
// Collection side of the serializer: captures each neuron's slice on its valid,
// tracks which slots are filled, and flags a second write to a filled slot.
module layer_collect_buf
  import layer_ser_pkg::*;
#(
  parameter int numNeuron = NUM_NEURON_DEF,
  parameter int dataWidth = DATA_W_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [numNeuron*dataWidth-1:0]      layer_in_i,
  input  logic [numNeuron-1:0]                layer_in_valid_i,
  input  logic                                xfer_i,
  output logic [numNeuron-1:0][dataWidth-1:0] buf_o,
  output logic                                collect_full_o,
  output logic                                overflow_o
);

  logic [numNeuron-1:0]                got_q, got_d, got_base, wr_en;
  logic [numNeuron-1:0][dataWidth-1:0] buf_q;
  logic                                full_q, ovf_q, ovf_hit;

  // A transfer frees every slot on the same edge, so a value landing then is
  // a fresh capture rather than a collision.
  always_comb begin
    got_base = xfer_i ? '0 : got_q;
    got_d    = got_base;
    wr_en    = '0;
    ovf_hit  = 1'b0;
    for (int i = 0; i < numNeuron; i++) begin
      if (layer_in_valid_i[i]) begin
        if (!got_base[i]) begin
          wr_en[i] = 1'b1;
          got_d[i] = 1'b1;
        end else begin
          ovf_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < numNeuron; i++) begin
      if (wr_en[i]) buf_q[i] <= layer_in_i[i*dataWidth +: dataWidth];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      got_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      got_q  <= got_d;
      full_q <= &got_d;
      ovf_q  <= ovf_q | ovf_hit;
    end
  end

  assign buf_o          = buf_q;
  assign collect_full_o = full_q;
  assign overflow_o     = ovf_q;

endmodule

// File: rtl/layer_out_serializer.sv
// Double-buffered serializer: gathers one layer's neuron outputs and replays
// them as a contiguous burst (neuron 0 first) followed by a two-cycle gap.
module layer_out_serializer
  import layer_ser_pkg::*;
#(
  parameter  int numNeuron = NUM_NEURON_DEF,
  parameter  int dataWidth = DATA_W_DEF,
  localparam int cntWidth  = $clog2(numNeuron)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron*dataWidth-1:0] layer_in,
  input  logic [numNeuron-1:0]           layer_in_valid,
  output logic [dataWidth-1:0]           myoutput,
  output logic                           myoutputValid,
  output logic                           busy,
  output logic                           collect_full,
  output logic                           overflow
);

  localparam logic [cntWidth:0] LAST = (cntWidth+1)'(numNeuron - 1);

  ser_state_t                          state_q, state_d;
  logic [cntWidth-1:0]                 cnt_q, cnt_d;
  logic [dataWidth-1:0]                out_q, out_d;
  logic                                vld_q, vld_d;
  logic                                xfer;
  logic [numNeuron-1:0][dataWidth-1:0] cbuf, stream_buf_q;

  layer_collect_buf #(
    .numNeuron(numNeuron),
    .dataWidth(dataWidth)
  ) u_collect (
    .clk             (clk),
    .rst             (rst),
    .layer_in_i      (layer_in),
    .layer_in_valid_i(layer_in_valid),
    .xfer_i          (xfer),
    .buf_o           (cbuf),
    .collect_full_o  (collect_full),
    .overflow_o      (overflow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (collect_full) begin
          xfer    = 1'b1;
          cnt_d   = '0;
          out_d   = cbuf[0];
          vld_d   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if ({1'b0, cnt_q} != LAST) begin
          cnt_d = cnt_q + cntWidth'(1);
          out_d = stream_buf_q[cnt_d];
          vld_d = 1'b1;
        end else begin
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  // The stream copy frees the collect buffer for the next layer result.
  always_ff @(posedge clk) begin
    if (xfer) stream_buf_q <= cbuf;
  end

  assign myoutput      = out_q;
  assign myoutputValid = vld_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer: directed scenarios plus random traffic on a
// 4-neuron instance against a burst-schedule model, and a 30-neuron burst.
module tb_layer_out_serializer;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int N2 = 30;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   lin;
  logic [N-1:0]     lval;
  logic [W-1:0]     dout;
  logic             dvld, dbusy, dfull, dovf;

  logic             rst2;
  logic [N2*W-1:0]  lin2;
  logic [N2-1:0]    lval2;
  logic [W-1:0]     dout2;
  logic             dvld2, dbusy2, dfull2, dovf2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  layer_out_serializer #(.numNeuron(N), .dataWidth(W)) dut (
    .clk(clk), .rst(rst), .layer_in(lin), .layer_in_valid(lval),
    .myoutput(dout), .myoutputValid(dvld), .busy(dbusy),
    .collect_full(dfull), .overflow(dovf)
  );

  layer_out_serializer #(.numNeuron(N2), .dataWidth(W)) dut30 (
    .clk(clk), .rst(rst2), .layer_in(lin2), .layer_in_valid(lval2),
    .myoutput(dout2), .myoutputValid(dvld2), .busy(dbusy2),
    .collect_full(dfull2), .overflow(dovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: slot contents plus a queue of beats still to be emitted.
  bit           m_got[N];
  logic [W-1:0] m_buf[N];
  bit           m_full, m_ovf, m_vld;
  logic [W-1:0] m_out;
  logic [W-1:0] beats[$];
  int           edge_no   = 0;
  int           free_edge = 0;

  task automatic model_edge(input bit r, input logic [N-1:0] v, input logic [N*W-1:0] d);
    bit xfer;
    if (r) begin
      for (int i = 0; i < N; i++) m_got[i] = 0;
      m_full = 0; m_ovf = 0; m_vld = 0; m_out = '0;
      beats.delete();
      free_edge = edge_no;
      return;
    end
    // A burst may start only once the previous burst and its 2-cycle gap are over.
    xfer = m_full && (edge_no >= free_edge);
    if (xfer) begin
      for (int i = 0; i < N; i++) begin
        beats.push_back(m_buf[i]);
        m_got[i] = 0;
      end
      free_edge = edge_no + N + 2;
    end
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (!m_got[i]) begin
          m_got[i] = 1;
          m_buf[i] = d[i*W +: W];
        end else begin
          m_ovf = 1;
        end
      end
    end
    m_full = 1;
    for (int i = 0; i < N; i++) if (!m_got[i]) m_full = 0;
    if (beats.size() > 0) begin
      m_out = beats.pop_front();
      m_vld = 1;
    end else begin
      m_vld = 0;
    end
  endtask

  task automatic step(input bit r, input logic [N-1:0] v, input logic [N*W-1:0] d);
    rst = r; lval = v; lin = d;
    @(posedge clk);
    edge_no++;
    model_edge(r, v, d);
    #1;
    chk("valid", {31'd0, dvld}, {31'd0, m_vld});
    chk("data",  {16'd0, dout}, {16'd0, m_out});
    chk("busy",  {31'd0, dbusy}, {31'd0, (edge_no <= free_edge - 2)});
    chk("full",  {31'd0, dfull}, {31'd0, m_full});
    chk("ovf",   {31'd0, dovf},  {31'd0, m_ovf});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, '0);
  endtask

  function automatic logic [N*W-1:0] pk(input logic [W-1:0] a, b, c, e);
    return {e, c, b, a};
  endfunction

  initial begin
    logic [N*W-1:0]  rd;
    logic [N-1:0]    rv;
    logic [W-1:0]    exp30[N2];
    bit              seen;

    rst = 1; lval = '0; lin = '0;
    rst2 = 1; lval2 = '0; lin2 = '0;
    step(1, '0, '0);
    step(1, '0, '0);
    rst2 = 0;
    chk("rst_vld", {31'd0, dvld}, 32'd0);
    chk("rst_busy", {31'd0, dbusy}, 32'd0);

    // basic burst
    step(0, 4'hF, pk(16'h0001, 16'h0002, 16'h0003, 16'h0004));
    chk("basic_full", {31'd0, dfull}, 32'd1);
    step(0, '0, '0);
    chk("basic_beat0", {16'd0, dout}, 32'h0001);
    idle(8);

    // staggered arrival
    step(0, 4'b1000, pk(16'h0, 16'h0, 16'h0, 16'h0D04));
    idle(2);
    step(0, 4'b0001, pk(16'h0D01, 16'h0, 16'h0, 16'h0));
    idle(2);
    step(0, 4'b0100, pk(16'h0, 16'h0, 16'h0D03, 16'h0));
    idle(2);
    chk("stag_nofull", {31'd0, dfull}, 32'd0);
    step(0, 4'b0010, pk(16'h0, 16'h0D02, 16'h0, 16'h0));
    idle(8);

    // overlap: second set arrives mid-burst
    step(0, 4'hF, pk(16'h0001, 16'h0002, 16'h0003, 16'h0004));
    idle(2);
    step(0, 4'hF, pk(16'h0010, 16'h0020, 16'h0030, 16'h0040));
    idle(14);

    // same-edge capture into slot 0 on the transfer edge
    step(0, 4'hF, pk(16'h0101, 16'h0102, 16'h0103, 16'h0104));
    step(0, 4'b0001, pk(16'h0055, 16'h0, 16'h0, 16'h0));
    idle(6);
    step(0, 4'b1110, pk(16'h0, 16'h0202, 16'h0203, 16'h0204));
    idle(10);
    chk("same_edge_ovf", {31'd0, dovf}, 32'd0);

    // overflow: second write to slot 2 is dropped
    step(0, 4'b0100, pk(16'h0, 16'h0, 16'h00AA, 16'h0));
    step(0, 4'b0100, pk(16'h0, 16'h0, 16'h00BB, 16'h0));
    chk("ovf_set", {31'd0, dovf}, 32'd1);
    step(0, 4'b1011, pk(16'h0A01, 16'h0A02, 16'h0, 16'h0A04));
    idle(8);
    chk("ovf_sticky", {31'd0, dovf}, 32'd1);

    // reset mid-burst
    step(0, 4'hF, pk(16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04));
    idle(2);
    step(1, '0, '0);
    chk("mid_rst_vld", {31'd0, dvld}, 32'd0);
    chk("mid_rst_busy", {31'd0, dbusy}, 32'd0);
    chk("mid_rst_full", {31'd0, dfull}, 32'd0);
    chk("mid_rst_ovf", {31'd0, dovf}, 32'd0);
    idle(6);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        rv[i] = ($urandom_range(0, 3) == 0);
        rd[i*W +: W] = W'($urandom);
      end
      step(($urandom_range(0, 149) == 0), rv, rd);
    end
    idle(12);

    // 30-neuron burst
    for (int i = 0; i < N2; i++) begin
      exp30[i] = W'($urandom);
      lin2[i*W +: W] = exp30[i];
    end
    lval2 = '1;
    @(posedge clk); #1;
    lval2 = '0;
    chk("b30_full", {31'd0, dfull2}, 32'd1);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      if (dvld2) seen = 1;
    end
    chk("b30_start", {31'd0, seen}, 32'd1);
    if (seen) begin
      for (int j = 0; j < N2; j++) begin
        chk("b30_vld", {31'd0, dvld2}, 32'd1);
        chk("b30_data", {16'd0, dout2}, {16'd0, exp30[j]});
        @(posedge clk); #1;
      end
      chk("b30_end", {31'd0, dvld2}, 32'd0);
      @(posedge clk); #1;
      chk("b30_idle", {31'd0, dbusy2}, 32'd0);
      chk("b30_ovf", {31'd0, dovf2}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
